// File: rtl/sram_controller.sv
// sram_controller
//   Multi-cycle data-memory responder for the MEM stage, backed by an external
//   16-bit asynchronous SRAM. Each 32-bit word takes two halfword accesses
//   (low half at the even SRAM address, high half at the odd one), followed
//   by WAIT_CYCLES idle settle cycles and a one-cycle DONE. `ready` is low
//   while an access is in flight so the pipeline freezes.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   wr_en, rd_en      store / load request (both high = store)
//   address           byte address, BASE_ADDR maps to SRAM word 0
//   write_data        store data
//   read_data         registered load result, held between loads
//   ready             1 = no access pending or access completes this cycle
//   SRAM_DQ           bidirectional SRAM data bus
//   SRAM_ADDR         SRAM halfword address (registered)
//   SRAM_WE_N         SRAM write strobe, active-low (registered)
//   SRAM_UB_N/LB_N/CE_N/OE_N  permanently enabled (0)
module sram_controller #(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOW  = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  logic [2:0]  state;
  logic        op_wr;
  logic [3:0]  cnt;
  logic [31:0] offs;
  logic [16:0] widx;
  logic        unused_offs;

  // Word index with 32-bit wrap; bits above w[16] alias onto the same SRAM word.
  assign offs        = address - BASE_ADDR;
  assign widx        = offs[18:2];
  assign unused_offs = ^{offs[31:19], offs[1:0]};

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign SRAM_DQ = (op_wr && state == S_LOW)  ? write_data[15:0]  :
                   (op_wr && state == S_HIGH) ? write_data[31:16] : 16'bz;

  assign ready = (state == S_IDLE && !wr_en && !rd_en) || (state == S_DONE);

  // SRAM_ADDR / SRAM_WE_N are loaded on the edge that enters each access
  // state, so they are stable registered values for the whole LOW/HIGH cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_wr     <= 1'b0;
      cnt       <= 4'd0;
      read_data <= 32'd0;
      SRAM_ADDR <= 18'd0;
      SRAM_WE_N <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (wr_en || rd_en) begin
          op_wr     <= wr_en;
          SRAM_ADDR <= {widx, 1'b0};
          SRAM_WE_N <= ~wr_en;
          state     <= S_LOW;
        end
        S_LOW: begin
          if (!op_wr) read_data[15:0] <= SRAM_DQ;
          SRAM_ADDR <= {widx, 1'b1};
          state     <= S_HIGH;
        end
        S_HIGH: begin
          if (!op_wr) read_data[31:16] <= SRAM_DQ;
          SRAM_WE_N <= 1'b1;
          if (WAIT_CYCLES == 0) begin
            state <= S_DONE;
          end else begin
            cnt   <= WAIT_INIT;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_DONE;
          else             cnt   <= cnt - 4'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle responder between the MEM stage's data-memory request (read/write, byte address, 32-bit store data) and an external 16-bit asynchronous SRAM. It replaces the single-cycle on-chip data memory. Each 32-bit word is split into two 16-bit SRAM accesses, followed by a programmable settle period. A combinational `ready` freezes the pipeline until the access completes.

## Interface
- `WAIT_CYCLES`, 3, number of idle settle cycles after the two halfword accesses (legal range 0..15).
- `BASE_ADDR`, 32'd1024, byte address mapped to SRAM word 0.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `wr_en` input 1: store request from the MEM stage.
- `rd_en` input 1: load request from the MEM stage.
- `address` input 32: byte address (ALU result).
- `write_data` input 32: store data (Val_Rm).
- `read_data` output 32: registered load result.
- `ready` output 1: high means no access is pending or the access completes this cycle; low means freeze the pipeline.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` output 18: SRAM halfword address.
- `SRAM_WE_N` output 1: SRAM write enable, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` output 1 each: tied to 0.

## Operation
- Word index `w = (address - BASE_ADDR) >> 2`, computed with 32-bit wrap-around. Only `w[16:0]` is used; higher bits are ignored (aliasing).
- Low halfword goes to `SRAM_ADDR = {w[16:0],1'b0}`; high halfword goes to `{w[16:0],1'b1}`. Word storage is little-endian across the two halves.
- FSM states are IDLE, LOW, HIGH, WAIT, DONE.
  - IDLE: if `wr_en | rd_en`, latch operation type and go to LOW. Otherwise stay.
  - LOW: go to HIGH.
  - HIGH: if `WAIT_CYCLES == 0`, go to DONE. Otherwise load the 4-bit counter with `WAIT_CYCLES - 1` and go to WAIT.
  - WAIT: decrement the counter. Go to DONE when it reaches 0.
  - DONE: go to IDLE unconditionally.
- `wr_en` and `rd_en` both high: treat as a write; no read occurs.
- LOW and HIGH during a write:
  - `SRAM_WE_N = 0`.
  - `SRAM_DQ` driven with `write_data[15:0]` in LOW and `write_data[31:16]` in HIGH.
- LOW and HIGH during a read:
  - `SRAM_WE_N = 1` and `SRAM_DQ` is high-Z.
  - `read_data[15:0]` captures `SRAM_DQ` at the end of LOW; `read_data[31:16]` captures it at the end of HIGH.
  - `read_data` holds its value in all other states.
- In IDLE, WAIT and DONE: `SRAM_WE_N = 1`, `SRAM_DQ` is high-Z, and `SRAM_ADDR` holds its last value.
- `ready = (state == IDLE & ~wr_en & ~rd_en) | (state == DONE)`, combinational.
- `address`, `write_data`, `wr_en` and `rd_en` must stay stable while `ready` is low. The controller does not re-latch them.

## Timing
- Reset values: state IDLE, `read_data = 0`, `SRAM_ADDR = 0`, `SRAM_WE_N = 1`, `SRAM_DQ` high-Z, counter 0. `ready` is therefore 1 whenever there is no request.
- A request first seen in IDLE at cycle 0 gives: LOW at cycle 1, HIGH at cycle 2, WAIT at cycles 3..2+WAIT_CYCLES, DONE at cycle 3+WAIT_CYCLES.
- With the default of 3, `ready` is low for cycles 0..5 and high in cycle 6. `read_data` is valid in cycle 6 and stays valid until the next read's LOW capture.
- Back-to-back requests: a request present in the cycle after DONE starts a fresh access from IDLE. There is no lost or duplicated access.
- `rst` asserted in any state: at the next edge, return to IDLE with the reset values above. An access interrupted mid-write may leave one halfword written; this is permitted.
- `SRAM_WE_N` and `SRAM_ADDR` are registered outputs. They are glitch-free and change only on `clk` edges.

## Test plan
- Reset, no request: `ready = 1`, `SRAM_WE_N = 1`, `read_data = 0`, `SRAM_DQ` high-Z.
- Write `0xDEADBEEF` to `address = 0x400`: SRAM model holds `0xBEEF` at 0 and `0xDEAD` at 1. `ready` is low for 6 cycles and high in cycle 6. `SRAM_WE_N` is low only in cycles 1–2.
- Read `address = 0x414` after writing `0x12345678` there: `SRAM_ADDR` is 10 then 11, and `read_data = 0x12345678` with `ready = 1` at cycle 6.
- `wr_en = rd_en = 1`, `address = 0x408`, data `0xCAFEF00D`: the write occurs and `read_data` is unchanged.
- `rst` pulsed at cycle 3 of a read: FSM is in IDLE next cycle, `read_data = 0`, and `ready` follows the request lines.
- `WAIT_CYCLES = 0`: DONE at cycle 3. Two back-to-back reads complete with exactly one IDLE cycle between DONEs.
